// File: rtl/reg_if_arbiter_if.sv
// Bundle of the two requester ports, the shared register-target port and the
// arbiter status outputs. The arbiter takes the slave view; the environment takes master.
interface reg_if_arbiter_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  i_m0_wr_rdy;
    logic                  i_m0_rd_req;
    logic [ADDR_WIDTH-1:0] i_m0_address;
    logic [31:0]           i_m0_wr_data;
    logic                  o_m0_wr_ack;
    logic                  o_m0_rd_rdy;
    logic [31:0]           o_m0_rd_data;
    logic                  o_m0_invalid_addr;

    logic                  i_m1_wr_rdy;
    logic                  i_m1_rd_req;
    logic [ADDR_WIDTH-1:0] i_m1_address;
    logic [31:0]           i_m1_wr_data;
    logic                  o_m1_wr_ack;
    logic                  o_m1_rd_rdy;
    logic [31:0]           o_m1_rd_data;
    logic                  o_m1_invalid_addr;

    logic                  o_reg_in_rdy;
    logic                  i_reg_in_ack;
    logic [ADDR_WIDTH-1:0] o_reg_address;
    logic [31:0]           o_reg_in_data;
    logic                  o_reg_out_req;
    logic                  i_reg_out_rdy;
    logic [31:0]           i_reg_out_data;
    logic                  i_reg_invalid_addr;

    logic [1:0]            o_grant;
    logic                  o_timeout;

    modport slave (
        input  i_m0_wr_rdy, i_m0_rd_req, i_m0_address, i_m0_wr_data,
        output o_m0_wr_ack, o_m0_rd_rdy, o_m0_rd_data, o_m0_invalid_addr,
        input  i_m1_wr_rdy, i_m1_rd_req, i_m1_address, i_m1_wr_data,
        output o_m1_wr_ack, o_m1_rd_rdy, o_m1_rd_data, o_m1_invalid_addr,
        output o_reg_in_rdy, o_reg_address, o_reg_in_data, o_reg_out_req,
        input  i_reg_in_ack, i_reg_out_rdy, i_reg_out_data, i_reg_invalid_addr,
        output o_grant, o_timeout
    );

    modport master (
        output i_m0_wr_rdy, i_m0_rd_req, i_m0_address, i_m0_wr_data,
        input  o_m0_wr_ack, o_m0_rd_rdy, o_m0_rd_data, o_m0_invalid_addr,
        output i_m1_wr_rdy, i_m1_rd_req, i_m1_address, i_m1_wr_data,
        input  o_m1_wr_ack, o_m1_rd_rdy, o_m1_rd_data, o_m1_invalid_addr,
        input  o_reg_in_rdy, o_reg_address, o_reg_in_data, o_reg_out_req,
        output i_reg_in_ack, i_reg_out_rdy, i_reg_out_data, i_reg_invalid_addr,
        input  o_grant, o_timeout
    );
endinterface

// File: rtl/reg_if_arbiter.sv
// Two-requester round-robin arbiter in front of a single register target,
// with a per-access wait counter that self-completes stalled accesses as errors.
module reg_if_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    reg_if_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, RELEASE} state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 grant_q, grant_d;
    logic                       last_q, last_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [31:0]                wdata_q, wdata_d;
    logic                       in_rdy_q, in_rdy_d;
    logic                       out_req_q, out_req_d;
    logic                       timeout_q, timeout_d;
    logic [1:0]                 wr_ack_q, wr_ack_d;
    logic [1:0]                 rd_rdy_q, rd_rdy_d;
    logic [1:0]                 inval_q, inval_d;
    logic [1:0][31:0]           rd_data_q, rd_data_d;

    logic [1:0]                 wr_rdy, rd_req, req;
    logic [1:0][ADDR_WIDTH-1:0] addr_in;
    logic [1:0][31:0]           wdata_in;
    logic                       win;
    logic                       own;
    logic                       at_timeout;

    assign wr_rdy   = {bus.i_m1_wr_rdy, bus.i_m0_wr_rdy};
    assign rd_req   = {bus.i_m1_rd_req, bus.i_m0_rd_req};
    assign addr_in  = {bus.i_m1_address, bus.i_m0_address};
    assign wdata_in = {bus.i_m1_wr_data, bus.i_m0_wr_data};
    assign req      = wr_rdy | rd_req;

    // On a tie the requester that was not served last wins.
    assign win        = (req == 2'b11) ? ~last_q : req[1];
    assign own        = grant_q[1];
    assign at_timeout = (cnt_q == 8'(TIMEOUT));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        in_rdy_d  = in_rdy_q;
        out_req_d = out_req_q;
        timeout_d = 1'b0;
        wr_ack_d  = 2'b00;
        rd_rdy_d  = 2'b00;
        inval_d   = 2'b00;
        rd_data_d = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = win ? 2'b10 : 2'b01;
                    last_d  = win;
                    cnt_d   = 8'd0;
                    addr_d  = addr_in[win];
                    wdata_d = wdata_in[win];
                    if (wr_rdy[win]) begin
                        in_rdy_d = 1'b1;
                        state_d  = WRITE;
                    end else begin
                        out_req_d = 1'b1;
                        state_d   = READ;
                    end
                end
            end
            WRITE: begin
                if (bus.i_reg_in_ack) begin
                    in_rdy_d      = 1'b0;
                    wr_ack_d[own] = 1'b1;
                    inval_d[own]  = bus.i_reg_invalid_addr;
                    state_d       = RELEASE;
                end else if (at_timeout) begin
                    in_rdy_d      = 1'b0;
                    wr_ack_d[own] = 1'b1;
                    inval_d[own]  = 1'b1;
                    timeout_d     = 1'b1;
                    state_d       = RELEASE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            READ: begin
                if (bus.i_reg_out_rdy) begin
                    out_req_d      = 1'b0;
                    rd_rdy_d[own]  = 1'b1;
                    rd_data_d[own] = bus.i_reg_out_data;
                    inval_d[own]   = bus.i_reg_invalid_addr;
                    state_d        = RELEASE;
                end else if (at_timeout) begin
                    out_req_d     = 1'b0;
                    rd_rdy_d[own] = 1'b1;
                    inval_d[own]  = 1'b1;
                    timeout_d     = 1'b1;
                    state_d       = RELEASE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RELEASE: begin
                // Hold the target until the owner lets go of both request lines.
                if (!wr_rdy[own] && !rd_req[own]) begin
                    grant_d = 2'b00;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            last_q    <= 1'b1;
            cnt_q     <= 8'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            in_rdy_q  <= 1'b0;
            out_req_q <= 1'b0;
            timeout_q <= 1'b0;
            wr_ack_q  <= 2'b00;
            rd_rdy_q  <= 2'b00;
            inval_q   <= 2'b00;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            in_rdy_q  <= in_rdy_d;
            out_req_q <= out_req_d;
            timeout_q <= timeout_d;
            wr_ack_q  <= wr_ack_d;
            rd_rdy_q  <= rd_rdy_d;
            inval_q   <= inval_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.o_m0_wr_ack       = wr_ack_q[0];
    assign bus.o_m0_rd_rdy       = rd_rdy_q[0];
    assign bus.o_m0_rd_data      = rd_data_q[0];
    assign bus.o_m0_invalid_addr = inval_q[0];
    assign bus.o_m1_wr_ack       = wr_ack_q[1];
    assign bus.o_m1_rd_rdy       = rd_rdy_q[1];
    assign bus.o_m1_rd_data      = rd_data_q[1];
    assign bus.o_m1_invalid_addr = inval_q[1];
    assign bus.o_reg_in_rdy      = in_rdy_q;
    assign bus.o_reg_out_req     = out_req_q;
    assign bus.o_reg_address     = addr_q;
    assign bus.o_reg_in_data     = wdata_q;
    assign bus.o_grant           = grant_q;
    assign bus.o_timeout         = timeout_q;
endmodule
